// File: rtl/vga_rd_buffer.sv
`default_nettype none
// ============================================================================
// Module      : vga_rd_buffer
// Description : FWFT pixel FIFO between the SDRAM burst reader and VGA timing.
//               Optional macro VGA_RD_BUF_STATS_EN adds a saturating
//               underflow_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_rd_buffer #(
    parameter int DATA_W       = 8,
    parameter int AW           = 10,
    parameter int BURST_LEN    = 8,
    parameter int ADDR_W       = 20,
    parameter int FRAME_PIXELS = 307200
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              frame_sync,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic              rd_data_vld,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_fifo_en,
    output logic [DATA_W-1:0] rgb_pixel,
    output logic [AW:0]       fifo_level,
`ifdef VGA_RD_BUF_STATS_EN
    output logic [15:0]       underflow_cnt,
`endif
    output logic              underflow
);

    localparam int              c_DEPTH   = 2 ** AW;
    localparam int              c_CNT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BURST_LEN - 1);
    localparam logic [AW:0]     c_DEPTH_L = (AW+1)'(c_DEPTH);
    localparam logic [AW:0]     c_BURST_L = (AW+1)'(BURST_LEN);
    localparam logic [ADDR_W-1:0] c_BURST_A = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] c_FRAME_A = ADDR_W'(FRAME_PIXELS);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_REQ   = 2'd1;
    localparam logic [1:0] c_BURST = 2'd2;
    localparam logic [1:0] c_FLUSH = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [DATA_W-1:0]  r_mem [c_DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_level;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [c_CNT_W-1:0] r_beat;
    logic               r_underflow;

    logic w_space_ok;
    logic w_addr_ok;
    logic w_beat;
    logic w_last_beat;
    logic w_push;
    logic w_pop;
    logic w_uflow;

    assign w_space_ok  = (c_DEPTH_L - r_level) >= c_BURST_L;
    assign w_addr_ok   = r_rd_addr < c_FRAME_A;
    assign w_beat      = rd_data_vld && ((r_state == c_BURST) || (r_state == c_FLUSH));
    assign w_last_beat = w_beat && (r_beat == c_LAST);
    assign w_push      = rd_data_vld && (r_state == c_BURST) && !frame_sync;
    assign w_pop       = rd_fifo_en && (r_level != '0) && !frame_sync;
    assign w_uflow     = rd_fifo_en && (r_level == '0);

    assign rd_req     = (r_state == c_REQ);
    assign rd_addr    = r_rd_addr;
    assign fifo_level = r_level;
    assign underflow  = r_underflow;
    assign rgb_pixel  = (r_level != '0) ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A frame_sync landing on the final beat has nothing left to flush.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (!frame_sync && w_space_ok && w_addr_ok) begin
                    w_state_nxt = c_REQ;
                end
            end
            c_REQ: begin
                if (frame_sync) begin
                    w_state_nxt = c_IDLE;
                end else if (rd_ack) begin
                    w_state_nxt = c_BURST;
                end
            end
            c_BURST: begin
                if (w_last_beat) begin
                    w_state_nxt = c_IDLE;
                end else if (frame_sync) begin
                    w_state_nxt = c_FLUSH;
                end
            end
            c_FLUSH: begin
                if (w_last_beat) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rd_data;
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (frame_sync) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + (AW+1)'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - (AW+1)'(1);
            end
        end
    end

    // Beats are counted through FLUSH so the discarded tail is tracked exactly.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_beat <= '0;
        end else if (w_beat) begin
            r_beat <= w_last_beat ? '0 : r_beat + c_CNT_W'(1);
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_rd_addr <= '0;
        end else if (frame_sync) begin
            r_rd_addr <= '0;
        end else if ((r_state == c_BURST) && w_last_beat) begin
            r_rd_addr <= r_rd_addr + c_BURST_A;
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_underflow <= 1'b0;
        end else if (w_uflow) begin
            r_underflow <= 1'b1;
        end
    end

`ifdef VGA_RD_BUF_STATS_EN
    logic [15:0] r_uflow_cnt;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_uflow_cnt <= '0;
        end else if (w_uflow && (r_uflow_cnt != 16'hFFFF)) begin
            r_uflow_cnt <= r_uflow_cnt + 16'd1;
        end
    end

    assign underflow_cnt = r_uflow_cnt;
`else
    // Only the sticky underflow flag is kept in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_rd_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_rd_buffer
// Description : Directed bench for vga_rd_buffer (full-frame and 64-pixel DUTs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_rd_buffer;

    logic       sclk = 1'b0;
    logic       rst;
    logic       frame_sync;
    logic       rd_ack;
    logic       rd_data_vld;
    logic [7:0] rd_data;
    logic       rd_fifo_en;
    logic       sel;

    int n_cmp = 0;
    int n_err = 0;

    always #5 sclk = ~sclk;

    logic        a_req, b_req, a_uf, b_uf;
    logic [19:0] a_addr, b_addr;
    logic [7:0]  a_pix, b_pix;
    logic [10:0] a_lvl, b_lvl;
`ifdef VGA_RD_BUF_STATS_EN
    logic [15:0] a_ucnt, b_ucnt;
`endif

    wire w_a_fs  = frame_sync  & ~sel;
    wire w_a_ack = rd_ack      & ~sel;
    wire w_a_vld = rd_data_vld & ~sel;
    wire w_a_en  = rd_fifo_en  & ~sel;
    wire w_b_fs  = frame_sync  & sel;
    wire w_b_ack = rd_ack      & sel;
    wire w_b_vld = rd_data_vld & sel;
    wire w_b_en  = rd_fifo_en  & sel;

    wire        w_req  = sel ? b_req  : a_req;
    wire [19:0] w_addr = sel ? b_addr : a_addr;
    wire [7:0]  w_pix  = sel ? b_pix  : a_pix;
    wire [10:0] w_lvl  = sel ? b_lvl  : a_lvl;
    wire        w_uf   = sel ? b_uf   : a_uf;

    vga_rd_buffer u_dut_a (
        .sclk(sclk), .rst(rst), .frame_sync(w_a_fs),
        .rd_req(a_req), .rd_addr(a_addr), .rd_ack(w_a_ack),
        .rd_data_vld(w_a_vld), .rd_data(rd_data), .rd_fifo_en(w_a_en),
        .rgb_pixel(a_pix), .fifo_level(a_lvl),
`ifdef VGA_RD_BUF_STATS_EN
        .underflow_cnt(a_ucnt),
`endif
        .underflow(a_uf)
    );

    vga_rd_buffer #(.FRAME_PIXELS(64)) u_dut_b (
        .sclk(sclk), .rst(rst), .frame_sync(w_b_fs),
        .rd_req(b_req), .rd_addr(b_addr), .rd_ack(w_b_ack),
        .rd_data_vld(w_b_vld), .rd_data(rd_data), .rd_fifo_en(w_b_en),
        .rgb_pixel(b_pix), .fifo_level(b_lvl),
`ifdef VGA_RD_BUF_STATS_EN
        .underflow_cnt(b_ucnt),
`endif
        .underflow(b_uf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; frame_sync = 1'b0; rd_ack = 1'b0;
        rd_data_vld = 1'b0; rd_data = 8'h00; rd_fifo_en = 1'b0;
        repeat (2) @(negedge sclk);
        check("rst_req", 32'(w_req), 0);
        check("rst_addr", 32'(w_addr), 0);
        check("rst_lvl", 32'(w_lvl), 0);
        check("rst_pix", 32'(w_pix), 0);
        check("rst_uf", 32'(w_uf), 0);
        rst = 1'b0;
        @(negedge sclk);
    endtask

    task automatic wait_req();
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (w_req) begin
                seen = 1'b1;
                break;
            end
            @(negedge sclk);
        end
        if (!seen) check("req_timeout", 32'(seen), 1);
    endtask

    task automatic send_words(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            rd_data_vld = 1'b1;
            rd_data     = base + 8'(k);
            @(negedge sclk);
        end
        rd_data_vld = 1'b0;
    endtask

    task automatic do_burst(input logic [7:0] base, output logic [19:0] addr);
        wait_req();
        addr   = w_addr;
        rd_ack = 1'b1;
        @(negedge sclk);
        rd_ack = 1'b0;
        send_words(base, 8);
    endtask

    initial begin
        logic [19:0] addr;
        int          nreq;
        sel = 1'b0;

        // Fill from empty with no pops: 128 bursts, then stall.
        do_reset();
        for (int i = 0; i < 128; i++) begin
            do_burst(8'(i * 8 + 1), addr);
            check("t1_addr", 32'(addr), 32'(i * 8));
        end
        nreq = 0;
        for (int c = 0; c < 20; c++) begin
            nreq += int'(w_req);
            @(negedge sclk);
        end
        check("t1_lvl", 32'(w_lvl), 1024);
        check("t1_noreq", 32'(nreq), 0);
        check("t1_head", 32'(w_pix), 8'h01);

        // FWFT drain of one burst.
        do_reset();
        do_burst(8'h00, addr);
        check("t2_lvl8", 32'(w_lvl), 8);
        for (int k = 0; k < 8; k++) begin
            rd_fifo_en = 1'b1;
            check("t2_pix", 32'(w_pix), 32'(k));
            @(negedge sclk);
        end
        rd_fifo_en = 1'b0;
        check("t2_lvl0", 32'(w_lvl), 0);
        check("t2_uf", 32'(w_uf), 0);

        // Pops on an empty FIFO.
        for (int k = 0; k < 3; k++) begin
            rd_fifo_en = 1'b1;
            check("t3_pix", 32'(w_pix), 0);
            @(negedge sclk);
        end
        rd_fifo_en = 1'b0;
        check("t3_lvl", 32'(w_lvl), 0);
        check("t3_uf", 32'(w_uf), 1);
`ifdef VGA_RD_BUF_STATS_EN
        check("t3_ucnt", 32'(a_ucnt), 3);
`endif

        // frame_sync part-way through the second burst.
        do_reset();
        do_burst(8'h40, addr);
        check("t4_addr0", 32'(addr), 0);
        wait_req();
        check("t4_addr8", 32'(w_addr), 8);
        rd_ack = 1'b1;
        @(negedge sclk);
        rd_ack = 1'b0;
        send_words(8'h50, 3);
        frame_sync = 1'b1;
        @(negedge sclk);
        frame_sync = 1'b0;
        check("t4_lvl_fs", 32'(w_lvl), 0);
        check("t4_addr_fs", 32'(w_addr), 0);
        check("t4_pix_fs", 32'(w_pix), 0);
        nreq = 0;
        for (int k = 0; k < 5; k++) begin
            rd_data_vld = 1'b1;
            rd_data     = 8'h60 + 8'(k);
            nreq += int'(w_req);
            @(negedge sclk);
        end
        rd_data_vld = 1'b0;
        check("t4_noreq_flush", 32'(nreq), 0);
        check("t4_lvl_end", 32'(w_lvl), 0);
        wait_req();
        check("t4_req_addr", 32'(w_addr), 0);

        // Simultaneous push and pop at level 5.
        do_reset();
        do_burst(8'h10, addr);
        for (int k = 0; k < 3; k++) begin
            rd_fifo_en = 1'b1;
            @(negedge sclk);
        end
        rd_fifo_en = 1'b0;
        check("t6_lvl5", 32'(w_lvl), 5);
        check("t6_head3", 32'(w_pix), 8'h13);
        wait_req();
        rd_ack = 1'b1;
        @(negedge sclk);
        rd_ack      = 1'b0;
        rd_data_vld = 1'b1;
        rd_data     = 8'hA0;
        rd_fifo_en  = 1'b1;
        @(negedge sclk);
        rd_fifo_en  = 1'b0;
        rd_data_vld = 1'b0;
        check("t6_lvl_pp", 32'(w_lvl), 5);
        check("t6_head4", 32'(w_pix), 8'h14);
        send_words(8'hA1, 7);
        check("t6_lvl12", 32'(w_lvl), 12);

        // 64-pixel frame with continuous pops.
        sel = 1'b1;
        do_reset();
        rd_fifo_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            do_burst(8'(i), addr);
            check("t5_addr", 32'(addr), 32'(i * 8));
        end
        nreq = 0;
        for (int c = 0; c < 60; c++) begin
            nreq += int'(w_req);
            @(negedge sclk);
        end
        check("t5_noreq", 32'(nreq), 0);
        check("t5_addr_end", 32'(w_addr), 64);
        frame_sync = 1'b1;
        @(negedge sclk);
        frame_sync = 1'b0;
        check("t5_addr_fs", 32'(w_addr), 0);
        wait_req();
        check("t5_req_after_fs", 32'(w_req), 1);
        check("t5_addr_re", 32'(w_addr), 0);
        rd_fifo_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
